// File: rtl/unary_add_nch.sv
// rtl/unary_add_nch.sv - multi-channel unary accumulator with unary burst playback
// Define UNARY_ADD_SAT_EN for a saturating counter with sticky C; default wraps with a C pulse.
module unary_add_nch #(
  parameter int NCH    = 2,
  parameter int CW     = 5,
  parameter int MAXCNT = 30
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           read_or_write,
  input  logic [NCH-1:0] din,
  output logic           dout,
  output logic           C,
  output logic           done,
  output logic           busy
);

  localparam int SW = CW + $clog2(NCH + 1);

  typedef enum logic [1:0] {ACCUM, EMIT, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [CW-1:0] remaining, remaining_n;
  logic          dout_n, c_n, done_n;
  logic [SW-1:0] pop, sum, acc_val;
  logic          acc_c, c_hold;

  // Sum is formed wide enough that one cycle's popcount can never overflow it.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) begin
      pop = pop + SW'(din[i]);
    end
    sum = SW'(count) + pop;
  end

`ifdef UNARY_ADD_SAT_EN
  always_comb begin
    c_hold = C;
    if (sum > SW'(MAXCNT)) begin
      acc_val = SW'(MAXCNT);
      acc_c   = 1'b1;
    end else begin
      acc_val = sum;
      acc_c   = C;
    end
  end
`else
  // C is a pulse here, so it falls back to 0 whenever nothing wraps.
  always_comb begin
    c_hold  = 1'b0;
    acc_val = sum % SW'(MAXCNT + 1);
    acc_c   = (sum > SW'(MAXCNT));
  end
`endif

  always_comb begin
    state_n     = state;
    count_n     = count;
    remaining_n = remaining;
    dout_n      = 1'b0;
    c_n         = c_hold;
    done_n      = 1'b0;
    case (state)
      ACCUM: begin
        if (read_or_write) begin
          remaining_n = count;
          state_n     = EMIT;
        end else if (en) begin
          count_n = CW'(acc_val);
          c_n     = acc_c;
        end
      end
      EMIT: begin
        // Dropping read_or_write aborts the burst even while paused.
        if (!read_or_write) begin
          state_n     = ACCUM;
          count_n     = '0;
          remaining_n = '0;
          c_n         = 1'b0;
        end else if (en) begin
          if (remaining != '0) begin
            dout_n      = 1'b1;
            remaining_n = remaining - CW'(1);
          end else begin
            done_n  = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (!read_or_write) begin
          count_n = '0;
          c_n     = 1'b0;
          state_n = ACCUM;
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      count     <= '0;
      remaining <= '0;
      dout      <= 1'b0;
      C         <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      remaining <= remaining_n;
      dout      <= dout_n;
      C         <= c_n;
      done      <= done_n;
    end
  end

  assign busy = (state == EMIT);

endmodule

// File: doc/unary_add_nch.md
# unary_add_nch

Parametrised multi-channel unary (bitstream) accumulator. Each cycle in accumulate mode it adds the number of ones present across `NCH` unary input streams into a counter. On command it plays the total back as a unary burst on `dout`, that is, `dout` high for exactly `count` cycles. This is the generalised successor of the fixed two-input unary adder in the unary arithmetic datapath. It adds per-cycle popcount, configurable width and capacity, overflow policy, playback pause/abort and a completion pulse.

## Interface
- `NCH`, default 2: number of unary input channels (≥1).
- `CW`, default 5: counter width in bits.
- `MAXCNT`, default 30: counter capacity; must satisfy `MAXCNT ≤ 2^CW−1`.

- `clk`  in  1: rising-edge clock, the only clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `en`  in  1: global enable; 0 freezes accumulation and pauses playback.
- `read_or_write`  in  1: 0 = accumulate (read inputs), 1 = play back (write count out).
- `din`  in  NCH: unary input bits, one per channel.
- `dout`  out  1: registered unary output stream.
- `C`  out  1: overflow/carry flag (policy set by macro).
- `done`  out  1: one-cycle pulse when playback completes.
- `busy`  out  1: high while in EMIT.

## Operation
- States: ACCUM (reset state), EMIT, DONE.
- **ACCUM**
  - On each edge with `en=1` and `read_or_write=0`: `count += popcount(din)`.
  - The sum is computed at `CW+$clog2(NCH+1)` bits, then the overflow policy is applied.
  - On an edge with `read_or_write=1`: load `remaining = count` and go to EMIT. `din` is ignored on that edge.
- **EMIT**
  - Edge with `en=1` and `remaining>0`: `dout<=1`, `remaining--`.
  - Edge with `en=1` and `remaining==0`: `dout<=0`, `done<=1`, go to DONE.
  - Edge with `en=0`: `dout<=0`, and `remaining` and state are held (pause). No ones are lost.
  - Edge with `read_or_write=0`, which takes priority over `en`: abort. `dout<=0`, `count<=0`, `C<=0`, no `done` pulse, go to ACCUM.
- **DONE**
  - `dout=0`, `count` retained.
  - When `read_or_write=0` is sampled: clear `count` and `C`, go to ACCUM. That edge's `din` is not accumulated.
- `busy` is high exactly while the state is EMIT.
- An asynchronous `rst_n` assertion at any point, including mid-playback, immediately forces ACCUM with all outputs 0.

## Timing
- Reset values: `dout=0`, `C=0`, `done=0`, `busy=0`, `count=0`, `remaining=0`, state ACCUM.
- `din` sampled on edge t is reflected in `count` after edge t (1-cycle latency).
- For a mode switch sampled on edge k with `count=N` and `en=1` throughout:
  - `dout` is high after edges k+1 … k+N.
  - `done` is high for the single cycle after edge k+N+1.
  - `busy` is high from after edge k through after edge k+N.
- `N=0`: `dout` never rises, and `done` pulses after edge k+1.
- Each cycle of `en=0` during EMIT extends the burst by one cycle. The burst is therefore not contiguous, but the total count of high cycles still equals N.
- `done` is never asserted for two consecutive cycles.

## Configuration
- `UNARY_ADD_SAT_EN` defined:
  - The counter saturates at `MAXCNT`.
  - `C` is sticky: it is set on the first accumulation whose true sum exceeds `MAXCNT`.
  - `C` is cleared only by reset, by abort, or by the DONE→ACCUM transition.
- `UNARY_ADD_SAT_EN` undefined:
  - The counter wraps modulo `MAXCNT+1`.
  - `C` is a one-cycle pulse on each edge where a wrap occurs.
  - `C` is never asserted outside ACCUM.

## Test plan
Default parameters unless noted.
1. Reset; `en=1`, `din=2'b11` for 10 cycles; then `read_or_write=1` → `dout` high for exactly 20 contiguous cycles starting one edge after the switch; `done` pulses once the cycle after; `C=0`.
2. `din=2'b11` for 19 cycles (true sum 38):
   - With `UNARY_ADD_SAT_EN`: `C` rises after the 16th edge and stays high; playback gives 30 ones.
   - Without it: one `C` pulse, after the 16th edge; playback gives 7 ones (38 mod 31).
3. No accumulation; switch to write → `dout` stays 0, `done` pulses after edge k+1; then `read_or_write=0` → ACCUM with `count=0`.
4. Accumulate 8; during playback hold `en=0` for 3 cycles after the 4th one → 8 total `dout` ones spread over 11 cycles, `done` delayed by 3 cycles; second run drops `read_or_write` after 4 ones → `dout=0` next cycle, no `done`, a later playback of 0 accumulations gives 0 ones.
5. Assert `rst_n=0` asynchronously mid-burst (between edges) → `dout`, `busy`, `C` go 0 immediately; after release a fresh accumulate of 5 plays back 5 ones.
6. `NCH=4`, `CW=6`, `MAXCNT=63`; `din=4'b1011`, then `4'b1111`, then `4'b0000` → `count` 3, 7, 7; playback gives 7 ones.
